bias_sram_ctrl: RTL

Controller for the 24-entry x 10-bit bias SRAM. It accepts a serial bias stream from the parameter loader and writes it to consecutive addresses 0..23. It also serves per-layer bias fetches from the conv engine by issuing three sequential reads and returning the three biases of one layer as a single bundle. It is the only master driving the bias SRAM's csb/wsb/addr/wdata pins, and arbitrates between loader and engine.

---
 rtl/bias_sram_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bias_sram_ctrl.sv
// Bias SRAM controller: sole master of the 24x10 bias SRAM.
// Writes a serial loader stream to addresses 0..23 (wrapping), and serves
// per-layer fetches as three sequential reads returned as one bundle.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   load_valid/load_data    loader word in; load_ready accepts it
//   loaded                  all 24 words written at least once since reset
//   fetch_req/fetch_layer   engine fetch request; fetch_ready accepts it
//   bias_valid, bias0..2    one-cycle pulse with the fetched layer's biases
//   sram_*                  SRAM pins (csb/wsb active-low), sram_rdata in
module bias_sram_ctrl #(
  parameter int unsigned BW_PER_PARAM = 10,
  parameter int unsigned NUM_LAYERS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic [BW_PER_PARAM-1:0] load_data,
  output logic                    load_ready,
  output logic                    loaded,
  input  logic                    fetch_req,
  input  logic [2:0]              fetch_layer,
  output logic                    fetch_ready,
  output logic                    bias_valid,
  output logic [BW_PER_PARAM-1:0] bias0,
  output logic [BW_PER_PARAM-1:0] bias1,
  output logic [BW_PER_PARAM-1:0] bias2,
  output logic                    sram_csb,
  output logic                    sram_wsb,
  output logic [4:0]              sram_waddr,
  output logic [4:0]              sram_raddr,
  output logic [BW_PER_PARAM-1:0] sram_wdata,
  input  logic [BW_PER_PARAM-1:0] sram_rdata
);

  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] LAST_ADDR = AW'(3 * NUM_LAYERS - 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WAIT} state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] base;
  logic          write_en;
  logic          fetch_en;

  // Next state, accept handshakes and SRAM pin drive.
  always_comb begin
    next_state  = state;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    write_en    = 1'b0;
    fetch_en    = 1'b0;
    sram_csb    = 1'b1;
    sram_wsb    = 1'b1;
    sram_waddr  = '0;
    sram_raddr  = '0;
    sram_wdata  = '0;
    case (state)
      IDLE: begin
        load_ready  = 1'b1;
        // Loader wins over a simultaneous fetch.
        fetch_ready = loaded & ~load_valid;
        write_en    = load_valid;
        fetch_en    = fetch_req & fetch_ready;
        if (write_en) begin
          sram_csb   = 1'b0;
          sram_wsb   = 1'b0;
          sram_waddr = wptr;
          sram_wdata = load_data;
        end
        if (fetch_en) next_state = RD0;
      end
      RD0: begin
        sram_csb   = 1'b0;
        sram_raddr = base;
        next_state = RD1;
      end
      RD1: begin
        sram_csb   = 1'b0;
        sram_raddr = base + AW'(1);
        next_state = RD2;
      end
      RD2: begin
        sram_csb   = 1'b0;
        sram_raddr = base + AW'(2);
        next_state = WAIT;
      end
      WAIT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, write pointer, fetch base and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wptr       <= '0;
      loaded     <= 1'b0;
      base       <= '0;
      bias_valid <= 1'b0;
      bias0      <= '0;
      bias1      <= '0;
      bias2      <= '0;
    end else begin
      state      <= next_state;
      bias_valid <= (state == WAIT);
      if (write_en) begin
        wptr <= (wptr == LAST_ADDR) ? '0 : wptr + AW'(1);
        if (wptr == LAST_ADDR) loaded <= 1'b1;
      end
      if (fetch_en) base <= AW'({fetch_layer, 1'b0}) + AW'(fetch_layer);
      // Read data lags the issued address by one cycle.
      case (state)
        RD1:     bias0 <= sram_rdata;
        RD2:     bias1 <= sram_rdata;
        WAIT:    bias2 <= sram_rdata;
        default: ;
      endcase
    end
  end

endmodule
